// File: rtl/multicycle_control_if.sv
// Bus between the multicycle control FSM and the datapath/memory it drives.
// The master modport is the controller side; the slave modport is the datapath side.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [4:0] rt;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       regdest;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrc_a;
  logic [1:0] alusrc_b;
  logic [1:0] aluop;
  logic [2:0] branch;
  logic [1:0] immedateop;
  logic [1:0] pc_source;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, rt, mem_ready,
    output pc_write, pc_write_cond, iord, ir_write, mem_read, mem_write,
           regdest, memtoreg, regwrite, alusrc_a, alusrc_b, aluop, branch,
           immedateop, pc_source, illegal, state
  );

  modport slave (
    output opcode, rt, mem_ready,
    input  pc_write, pc_write_cond, iord, ir_write, mem_read, mem_write,
           regdest, memtoreg, regwrite, alusrc_a, alusrc_b, aluop, branch,
           immedateop, pc_source, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath.
// Define MC_BRANCH_EXT_EN to decode bgtz (000111) and the regimm (000001) branches.
module multicycle_control (
  input  logic                        clk,
  input  logic                        reset_n,
  multicycle_control_if.master        bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB    = 4'd7,
    S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP   = 4'd11,
    S_JAL    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
`ifdef MC_BRANCH_EXT_EN
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
`endif

  state_t     r_state, w_next;
  logic       w_pc_write, w_pc_write_cond, w_iord, w_ir_write, w_mem_read, w_mem_write;
  logic       w_regdest, w_memtoreg, w_regwrite, w_alusrc_a, w_illegal;
  logic [1:0] w_alusrc_b, w_aluop, w_immop, w_pc_source;
  logic [2:0] w_branch;

  // NOTE: non-blocking assignment for every sequential register so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_immop = (bus.opcode == OP_ANDI) ? 2'b10 :
              (bus.opcode == OP_ADDI) ? 2'b01 : 2'b00;
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    w_next          = r_state;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_regdest       = 1'b0;
    w_memtoreg      = 1'b0;
    w_regwrite      = 1'b0;
    w_alusrc_a      = 1'b0;
    w_alusrc_b      = 2'd0;
    w_aluop         = 2'd0;
    w_branch        = 3'b000;
    w_immedateop_clear();
    w_pc_source     = 2'd0;
    w_illegal       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_alusrc_b = 2'd1;
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alusrc_b = 2'd3;
        case (bus.opcode)
          OP_RTYPE:        w_next = S_EXEC;
          OP_LW, OP_SW:    w_next = S_MEMADR;
          OP_BEQ, OP_BNE:  w_next = S_BRANCH;
`ifdef MC_BRANCH_EXT_EN
          OP_BGTZ, OP_REGIMM: w_next = S_BRANCH;
`endif
          OP_ADDI, OP_ANDI: w_next = S_IEXEC;
          OP_J:            w_next = S_JUMP;
          OP_JAL:          w_next = S_JAL;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrc_a = 1'b1;
        w_alusrc_b = 2'd2;
        w_next     = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (bus.mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (bus.mem_ready) w_next = S_FETCH;
      end
      S_EXEC: begin
        w_alusrc_a = 1'b1;
        w_aluop    = 2'd2;
        w_next     = S_RWB;
      end
      S_RWB: begin
        w_regwrite = 1'b1;
        w_regdest  = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        w_alusrc_a      = 1'b1;
        w_aluop         = 2'd1;
        w_pc_source     = 2'd1;
        w_pc_write_cond = 1'b1;
        case (bus.opcode)
          OP_BEQ: w_branch = 3'b001;
          OP_BNE: w_branch = 3'b010;
`ifdef MC_BRANCH_EXT_EN
          OP_BGTZ: begin
            if (bus.rt == 5'd0) w_branch = 3'b011;
            else                w_pc_write_cond = 1'b0;
          end
          OP_REGIMM: begin
            if (bus.rt == 5'd1)      w_branch = 3'b100;
            else if (bus.rt == 5'd0) w_branch = 3'b101;
            else                     w_pc_write_cond = 1'b0;
          end
`endif
          default: w_pc_write_cond = 1'b0;
        endcase
        w_next = S_FETCH;
      end
      S_IEXEC: begin
        w_alusrc_a = 1'b1;
        w_alusrc_b = 2'd2;
        w_aluop    = 2'd3;
        w_next     = S_IWB;
      end
      S_IWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = 2'd2;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        w_pc_write  = 1'b1;
        w_pc_source = 2'd2;
        w_regwrite  = 1'b1;
        w_next      = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Empty helper: immediate-op is driven only in the two immediate states, at the output.
  function automatic void w_immedateop_clear();
  endfunction

`ifndef MC_BRANCH_EXT_EN
  logic w_unused_rt;
  assign w_unused_rt = ^bus.rt;
`endif

  // Reset gates every output directly so strobes drop the instant reset_n falls.
  assign bus.pc_write      = reset_n & w_pc_write;
  assign bus.pc_write_cond = reset_n & w_pc_write_cond;
  assign bus.iord          = reset_n & w_iord;
  assign bus.ir_write      = reset_n & w_ir_write;
  assign bus.mem_read      = reset_n & w_mem_read;
  assign bus.mem_write     = reset_n & w_mem_write;
  assign bus.regdest       = reset_n & w_regdest;
  assign bus.memtoreg      = reset_n & w_memtoreg;
  assign bus.regwrite      = reset_n & w_regwrite;
  assign bus.alusrc_a      = reset_n & w_alusrc_a;
  assign bus.illegal       = reset_n & w_illegal;
  assign bus.alusrc_b      = reset_n ? w_alusrc_b  : 2'd0;
  assign bus.aluop         = reset_n ? w_aluop     : 2'd0;
  assign bus.branch        = reset_n ? w_branch    : 3'b000;
  assign bus.pc_source     = reset_n ? w_pc_source : 2'd0;
  assign bus.immedateop    = (reset_n && (r_state == S_IEXEC || r_state == S_IWB)) ? w_immop : 2'b00;
  assign bus.state         = r_state;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have these ports (name direction width meaning):
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  6  instruction opcode, sampled from the instruction register
- rt  in  5  rt field, used for branch-variant decode
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write, pc_write_cond, iord, ir_write  out  1 each  PC / instruction-register / address-mux controls
- mem_read, mem_write  out  1 each  memory request strobes
- regdest, memtoreg, regwrite  out  1 each  register-file controls
- alusrc_a  out  1  ALU A source: 0=PC, 1=reg A
- alusrc_b  out  2  ALU B source: 0=reg B, 1=const 4, 2=sign-extended imm, 3=imm<<2
- aluop  out  2  ALU op class: 0=add, 1=branch compare, 2=R-type funct, 3=immediate
- branch  out  3  branch kind: 001 beq, 010 bne, 011 bgtz, 100 bgez, 101 blez/bltz class, 000 none
- immedateop  out  2  01 addi, 10 andi, 00 none
- pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target
- illegal  out  1  one-cycle pulse on an undecodable opcode
- state  out  4  current FSM state, for debug
REQ-002 Clock and reset: one clock (clk); reset (reset_n) is asynchronous and active-low.

Function
REQ-003 Moore FSM; states (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11, JAL 12.
REQ-004 FETCH: mem_read=1, iord=0, alusrc_a=0, alusrc_b=1, aluop=0, pc_source=0.
- Hold FETCH while mem_ready=0.
- When mem_ready=1: ir_write=1 and pc_write=1 for exactly that cycle; next state DECODE.
REQ-005 DECODE: alusrc_a=0, alusrc_b=3, aluop=0 (branch target precompute). Next state by opcode:
- 000000 -> EXEC
- 100011 / 101011 -> MEMADR
- 000100, 000101, 000111, 000001 -> BRANCH
- 001000 / 001100 -> IEXEC
- 000010 -> JUMP
- 000011 -> JAL
- any other -> FETCH, with illegal=1 for one cycle
REQ-006 MEMADR: alusrc_a=1, alusrc_b=2, aluop=0. Next state MEMRD for lw, MEMWR for sw.
REQ-007 MEMRD: mem_read=1, iord=1; hold until mem_ready=1, then MEMWB. MEMWB: regwrite=1, memtoreg=1, regdest=0; then FETCH.
REQ-008 MEMWR: mem_write=1, iord=1; hold until mem_ready=1, then FETCH.
REQ-009 EXEC: alusrc_a=1, alusrc_b=0, aluop=2; then RWB. RWB: regwrite=1, regdest=1, memtoreg=0; then FETCH.
REQ-010 BRANCH:
- alusrc_a=1, alusrc_b=0, aluop=1, pc_write_cond=1, pc_source=1.
- branch per REQ-001, decoded from opcode/rt: 000111 with rt=0 -> 011; 000001 with rt=1 -> 100, rt=0 -> 101.
- Unmatched rt -> branch=000, pc_write_cond=0.
- Next state FETCH.
REQ-011 IEXEC: alusrc_a=1, alusrc_b=2, aluop=3, immedateop per REQ-001; then IWB. IWB: regwrite=1, regdest=0, memtoreg=0, immedateop held; then FETCH.
REQ-012 JUMP: pc_write=1, pc_source=2; then FETCH. JAL: pc_write=1, pc_source=2, regwrite=1 (link write); then FETCH.
REQ-013 Any output not named for a state SHALL be 0 in that state.
REQ-014 Memory strobes stay asserted and stable until the cycle mem_ready=1. mem_ready outside FETCH/MEMRD/MEMWR is ignored.
REQ-015 Cycle counts with mem_ready tied to 1: R-type 4, lw 5, sw 4, branch 3, addi/andi 4, j 3, jal 3.

Reset
REQ-016 reset_n=0 immediately sets state=FETCH and forces every output to 0, including pc_write, ir_write and mem_read.
REQ-017 Reset asserted mid-instruction (including mid-handshake) abandons that instruction. No write strobe may be asserted while reset_n=0.
REQ-018 In the first cycle after reset_n rises, the block issues a FETCH with mem_read=1.

Configuration
REQ-019 Macro MC_BRANCH_EXT_EN.
- Defined: opcodes 000111 and 000001 decode per REQ-010.
- Undefined: both opcodes are illegal (DECODE -> FETCH, illegal pulse), and branch is only ever 000, 001 or 010.

Verification
REQ-020 Reset release, mem_ready=1, opcode=000000: state sequence 0,1,6,7,0. regwrite=1 and regdest=1 only in state 7.
REQ-021 opcode=100011, mem_ready=0 for 3 cycles in MEMRD: mem_read=1 and iord=1 held 4 cycles, then MEMWB with memtoreg=1, regwrite=1.
REQ-022 opcode=000001, rt=00001, with MC_BRANCH_EXT_EN: BRANCH state shows branch=100, pc_write_cond=1. Without the macro: illegal=1 in DECODE, next state 0.
REQ-023 opcode=111111: illegal pulses 1 cycle, no regwrite/mem_write/pc_write_cond, returns to FETCH.
REQ-024 reset_n dropped during MEMWR with mem_ready=0: mem_write falls to 0 asynchronously and state=0. After release, FETCH with mem_read=1.
REQ-025 opcode=001100 (andi): sequence 0,1,9,10,0. immedateop=10 in 9 and 10; alusrc_b=2 and aluop=3 in 9.
